// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the
// shared single-port memory.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        m_en;
  logic        m_we;
  logic [3:0]  m_wstrb;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  // Arbiter side: takes requests and memory read data, drives everything else.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
    output i_ready, i_rvalid, i_rdata, i_err,
    output d_ready, d_rvalid, d_rdata, d_err,
    output m_en, m_we, m_wstrb, m_addr, m_wdata
  );

  // Requester/memory side: the mirror image of the arbiter view.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata,
    input  i_ready, i_rvalid, i_rdata, i_err,
    input  d_ready, d_rvalid, d_rdata, d_err,
    input  m_en, m_we, m_wstrb, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch and load/store ports, with range checking and grant counters.
module mem_arbiter #(
  parameter int MEM_WORDS = 4096,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  logic [29:0] i_word, d_word;
  logic        i_oor, d_oor;
  logic        grant_i, grant_d;
  logic        last_grant_d;

  logic        resp_valid_p1;
  logic        resp_port_d_p1;
  logic        resp_err_p1;
  logic        resp_is_write_p1;

  logic [CNT_W-1:0] i_grant_cnt;
  logic [CNT_W-1:0] d_grant_cnt;

  logic resp_i, resp_d, rdata_ok;
  logic unused_addr_bits;

  function automatic logic out_of_range(input logic [29:0] word);
    return {2'b00, word} >= 32'(MEM_WORDS);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  assign i_word = bus.i_addr[31:2];
  assign d_word = bus.d_addr[31:2];
  assign i_oor  = out_of_range(i_word);
  assign d_oor  = out_of_range(d_word);
  assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  // On a tie the port that did not win the last accept goes next.
  assign grant_i = bus.i_req & (~bus.d_req | last_grant_d);
  assign grant_d = bus.d_req & ~grant_i;

  assign bus.i_ready = grant_i;
  assign bus.d_ready = grant_d;

  // ---- p0: accept cycle, drive memory for the winner ----
  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_wstrb = 4'b0000;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (grant_i && !i_oor) begin
      bus.m_en   = 1'b1;
      bus.m_addr = i_word;
    end else if (grant_d && !d_oor) begin
      bus.m_en    = 1'b1;
      bus.m_addr  = d_word;
      bus.m_we    = bus.d_we;
      bus.m_wstrb = bus.d_we ? bus.d_wstrb : 4'b0000;
      bus.m_wdata = bus.d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_valid_p1 <= 1'b0;
      last_grant_d  <= 1'b1;
      i_grant_cnt   <= '0;
      d_grant_cnt   <= '0;
    end else begin
      resp_valid_p1 <= grant_i | grant_d;
      if (grant_i) begin
        last_grant_d <= 1'b0;
        i_grant_cnt  <= sat_inc(i_grant_cnt);
      end
      if (grant_d) begin
        last_grant_d <= 1'b1;
        d_grant_cnt  <= sat_inc(d_grant_cnt);
      end
    end
  end

  // Response attributes are qualified by resp_valid_p1, so they need no reset.
  always_ff @(posedge clk) begin
    resp_port_d_p1   <= grant_d;
    resp_err_p1      <= grant_d ? d_oor : i_oor;
    resp_is_write_p1 <= grant_d & bus.d_we;
  end

  // ---- p1: response cycle, memory read data passes straight through ----
  assign resp_i   = resp_valid_p1 & ~resp_port_d_p1;
  assign resp_d   = resp_valid_p1 &  resp_port_d_p1;
  assign rdata_ok = ~resp_err_p1 & ~resp_is_write_p1;

  assign bus.i_rvalid = resp_i;
  assign bus.i_err    = resp_i & resp_err_p1;
  assign bus.i_rdata  = (resp_i & rdata_ok) ? bus.m_rdata : '0;

  assign bus.d_rvalid = resp_d;
  assign bus.d_err    = resp_d & resp_err_p1;
  assign bus.d_rdata  = (resp_d & rdata_ok) ? bus.m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a driver pushes hand-computed responses into a
// scoreboard queue, and a negedge monitor pops and compares each response.
module tb_mem_arbiter;
  localparam int MEM_WORDS = 4096;
  localparam int CNT_W     = 16;

  logic clk;
  logic reset_n;
  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_WORDS(MEM_WORDS), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous single port, byte-lane writes, registered read.
  logic [31:0] mem [0:MEM_WORDS-1];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.m_wstrb[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
      end else begin
        rd_q <= mem[bus.m_addr];
      end
    end
  end
  assign bus.m_rdata = rd_q;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit is_d, input logic [31:0] data, input bit err);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.err  = err;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: one response per pop, checked in the cycle it is due.
  always @(negedge clk) begin
    exp_t e;
    if (bus.i_rvalid || bus.d_rvalid) begin
      chk("rvalid_one_hot", {31'd0, bus.i_rvalid & bus.d_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, bus.d_rvalid, bus.i_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_port", {31'd0, bus.d_rvalid}, {31'd0, e.is_d});
        chk("rsp_data", bus.d_rvalid ? bus.d_rdata : bus.i_rdata, e.data);
        chk("rsp_err", {31'd0, bus.d_rvalid ? bus.d_err : bus.i_err}, {31'd0, e.err});
        chk("rsp_cycle", cyc, e.due);
        chk("idle_port_rdata", bus.d_rvalid ? bus.i_rdata : bus.d_rdata, 32'd0);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("missing_rvalid", 32'd0, 32'd1);
    end
  end

  // Sets up one request after the next posedge and waits (bounded) for ready.
  task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] exp_data, input bit exp_err, input string tag);
    bit got;
    @(posedge clk);
    #1;
    bus.i_req = !is_d;
    bus.d_req = is_d;
    if (is_d) begin
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      bus.d_wstrb = wstrb;
    end else begin
      bus.i_addr = addr;
    end
    got = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (is_d ? bus.d_ready : bus.i_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_ready"}, {31'd0, got}, 32'd1);
    if (got) push(is_d, exp_data, exp_err);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'hFFFF_FFFF;
    rd_q = 32'h0;
    reset_n = 1'b0;
    bus.i_req = 1'b0;  bus.i_addr = 32'h0;
    bus.d_req = 1'b0;  bus.d_we = 1'b0;  bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0; bus.d_wstrb = 4'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
    chk("rst_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
    chk("rst_i_err", {31'd0, bus.i_err}, 32'd0);
    chk("rst_d_err", {31'd0, bus.d_err}, 32'd0);
    chk("rst_ready", {30'd0, bus.i_ready, bus.d_ready}, 32'd0);
    chk("rst_m_en", {31'd0, bus.m_en}, 32'd0);
    chk("rst_i_cnt", 32'(dut.i_grant_cnt), 32'd0);
    chk("rst_d_cnt", 32'(dut.d_grant_cnt), 32'd0);

    // Single I read of word 4
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "i_read");
    chk("i_read_m_addr", 32'(bus.m_addr), 32'd4);
    chk("i_read_m_en", {31'd0, bus.m_en}, 32'd1);
    chk("i_read_m_we", {31'd0, bus.m_we}, 32'd0);

    // D partial write then same-word read back-to-back
    issue(1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, "d_write");
    chk("d_write_m_addr", 32'(bus.m_addr), 32'd8);
    chk("d_write_m_we", {31'd0, bus.m_we}, 32'd1);
    chk("d_write_m_wstrb", {28'd0, bus.m_wstrb}, 32'd3);
    chk("d_write_m_wdata", bus.m_wdata, 32'h1234_5678);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hFFFF_5678, 1'b0, "d_read");
    chk("d_read_m_we", {31'd0, bus.m_we}, 32'd0);
    idle();

    // Contention after reset: I, D, I, D
    do_reset();
    @(posedge clk);
    #1;
    bus.i_req = 1'b1;  bus.i_addr = 32'h10;
    bus.d_req = 1'b1;  bus.d_we = 1'b0;  bus.d_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tie_i_ready", {31'd0, bus.i_ready}, {31'd0, (k % 2) == 0});
      chk("tie_d_ready", {31'd0, bus.d_ready}, {31'd0, (k % 2) == 1});
      if ((k % 2) == 0) push(1'b0, 32'hDEAD_BEEF, 1'b0);
      else              push(1'b1, 32'hFFFF_5678, 1'b0);
    end
    idle();
    @(negedge clk);
    chk("tie_i_cnt", 32'(dut.i_grant_cnt), 32'd2);
    chk("tie_d_cnt", 32'(dut.d_grant_cnt), 32'd2);

    // Out-of-range D read at the first word past the end
    issue(1'b1, 1'b0, 32'(MEM_WORDS * 4), 32'h0, 4'h0, 32'h0, 1'b1, "oor");
    chk("oor_m_en", {31'd0, bus.m_en}, 32'd0);
    chk("oor_m_we", {31'd0, bus.m_we}, 32'd0);
    idle();
    @(negedge clk);
    chk("oor_d_cnt", 32'(dut.d_grant_cnt), 32'd3);

    // Back-to-back I reads, one accept per cycle
    issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_1111, 1'b0, "b2b0");
    issue(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h2222_2222, 1'b0, "b2b1");
    issue(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 32'h3333_3333, 1'b0, "b2b2");
    idle();
    repeat (2) @(negedge clk);

    // Reset in the accept cycle: no response, and the next tie goes to I
    @(posedge clk);
    #1;
    bus.i_req = 1'b1;  bus.i_addr = 32'h10;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_i_ready", {31'd0, bus.i_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    bus.i_req = 1'b1;  bus.i_addr = 32'h10;
    bus.d_req = 1'b1;  bus.d_we = 1'b0;  bus.d_addr = 32'h20;
    @(negedge clk);
    chk("rst_tie_i_ready", {31'd0, bus.i_ready}, 32'd1);
    chk("rst_tie_d_ready", {31'd0, bus.d_ready}, 32'd0);
    if (bus.i_ready) push(1'b0, 32'hDEAD_BEEF, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares one single-port synchronous memory between the core's instruction-fetch path and its load/store path. This replaces the separate ROM and data-memory buses with a unified instruction/data memory. Each port uses a request/ready accept handshake and a one-cycle-later rvalid response. The arbiter also range-checks addresses and keeps per-port grant counters for debug.

## Interface
- MEM_WORDS, 4096, number of 32-bit words in the memory; legal word index is 0..MEM_WORDS-1
- CNT_W, 16, width of the saturating grant counters
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- i_req  in  1  instruction port read request
- i_addr  in  32  instruction byte address; bits [1:0] ignored
- i_ready  out  1  instruction request accepted this cycle
- i_rvalid  out  1  instruction response valid
- i_rdata  out  32  instruction read data
- i_err  out  1  instruction response is an out-of-range error
- d_req  in  1  data port request
- d_we  in  1  data port write (1) or read (0)
- d_addr  in  32  data byte address; bits [1:0] ignored
- d_wdata  in  32  write data
- d_wstrb  in  4  byte write enables; bit n covers byte lane n
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid (read data or write ack)
- d_rdata  out  32  data read data; 0 for writes
- d_err  out  1  data response is an out-of-range error
- m_en  out  1  memory access enable
- m_we  out  1  memory write
- m_wstrb  out  4  memory byte enables
- m_addr  out  30  memory word index
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid one cycle after m_en with m_we=0

## Operation
- Requester rule: once req is raised, the requester holds req, addr, we, wdata and wstrb stable until ready=1. Ready is a single-cycle accept.
- Arbitration:
  - If only one port requests, that port wins.
  - If both request, the port that was not granted last wins.
  - last_grant updates only on an accept.
- The accept decision is combinational in the cycle of the request. There is exactly one winner per cycle. ready is asserted only to the winner.
- Range check: word = addr[31:2]. The access is out of range if word >= MEM_WORDS.
  - In range: m_en=1, m_addr=word, m_we=(port==D)&d_we, m_wstrb=d_wstrb for D writes (else 0), m_wdata=d_wdata.
  - Out of range: m_en=0 and m_we=0. The port is still accepted, and its response carries err=1.
- Response stage registers: resp_valid, resp_port, resp_err, resp_is_write.
  - Next cycle, resp_port's rvalid=1. The other port's rvalid stays 0.
  - rdata = m_rdata for an in-range read. rdata = 0 for writes or errors.
  - err = resp_err.
  - rdata of a non-responding port is 0.
- Pipelining: a new request may be accepted in the same cycle a prior response is presented. Sustained throughput is 1 transaction per cycle.
- Counters:
  - i_grant_cnt and d_grant_cnt are internal CNT_W-bit counters, one per port. The port's counter increments on each accept, including error accepts.
  - Each saturates at all-ones. They are not cleared except by reset.
  - They are exposed to the bench hierarchically only.

## Timing
- Reset (reset_n=0 at posedge):
  - resp_valid=0, so i_rvalid, d_rvalid, i_err and d_err are all 0 the following cycle.
  - last_grant=D, so I wins the first tie.
  - Both counters = 0.
  - A transaction accepted in the same cycle as reset gets no response. The requester must re-issue.
- Combinational outputs: i_ready, d_ready, m_* are 0 whenever both req are 0, independent of reset.
- Latency: accept in cycle N gives rvalid in cycle N+1, exactly one cycle high per accept.
- Read data: m_rdata is passed through combinationally in cycle N+1. There is no rdata register.
- Writes: the memory write commits at posedge N+1. d_rvalid with d_rdata=0 is the write ack in cycle N+1.
- Contention: with both requesting continuously, grants alternate I, D, I, D. Neither port waits more than one cycle.
- Same-word hazard: a read accepted in the cycle immediately after a write to the same word returns the new data. This relies on the memory being write-then-read across cycles. The arbiter does not forward.

## Test plan
- Reset then single I read: i_req=1, i_addr=0x10 with mem[4]=0xDEADBEEF. Required: i_ready=1 same cycle, m_addr=4; next cycle i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0.
- D write then read: write d_addr=0x20, d_wdata=0x12345678, d_wstrb=4'b0011 over old value 0xFFFFFFFF. Required: d_rvalid ack with d_rdata=0. Read of 0x20 next returns 0xFFFF5678.
- Contention after reset: i_req=d_req=1 held for 4 accepts. Required: grant order I, D, I, D; rvalid pulses on alternating ports; i_grant_cnt=d_grant_cnt=2.
- Out of range: d_addr=MEM_WORDS*4 read. Required: d_ready=1, m_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
- Back-to-back I reads at 0x0, 0x4, 0x8. Required: one accept per cycle; rvalid high 3 consecutive cycles with the matching data.
- Reset mid-transaction: accept I read, assert reset_n=0 that cycle. Required: i_rvalid=0 next cycle; a subsequent tie is granted to I.
